// File: rtl/reg_scoreboard.sv
// Multi-lane in-order register scoreboard for the issue stage.
// Ports: clk_i/rst_i, per-lane decode inputs, writeback releases,
//   mem/blocking completions; gnt_o, locks_o, mem_busy_o, blocked_o.
module reg_scoreboard #(
  parameter int NR = 32,
  parameter int NI = 2,
  parameter int NW = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NI-1:0]             pl_valid_i,
  input  logic [NI-1:0]             blocking_i,
  input  logic [NI*$clog2(NR)-1:0]  rd_i,
  input  logic [NI*NR-1:0]          reg_req_i,
  input  logic [NI-1:0]             mem_op_i,
  input  logic [NW-1:0]             wb_valid_i,
  input  logic [NW*$clog2(NR)-1:0]  wb_rd_i,
  input  logic                      mem_done_i,
  input  logic                      blk_done_i,
  output logic [NI-1:0]             gnt_o,
  output logic [NR-1:0]             locks_o,
  output logic                      mem_busy_o,
  output logic                      blocked_o
);

  localparam int L = $clog2(NR);

  logic [NR-1:0] locks_q;
  logic          mem_busy_q;
  logic          blocked_q;

  logic [NR-1:0] wb_clr;
  logic [NR-1:0] eff;
  logic [NR-1:0] set_v;
  logic [NI-1:0] gnt;
  logic          mem_gnt;
  logic          blk_gnt;
  logic [L-1:0]  lane_rd;
  logic          lane_ok;
  logic          prev_ok;

  // Registers released by writeback this cycle; r0 is never locked.
  always_comb begin
    wb_clr = '0;
    for (int w = 0; w < NW; w++) begin
      if (wb_valid_i[w]) wb_clr[wb_rd_i[w*L +: L]] = 1'b1;
    end
    wb_clr[0] = 1'b0;
  end

  // Lanes are walked oldest first; eff accumulates the rd claims of
  // already-granted lanes so younger lanes see intra-group hazards.
  always_comb begin
    eff     = locks_q & ~wb_clr;
    set_v   = '0;
    gnt     = '0;
    mem_gnt = 1'b0;
    blk_gnt = 1'b0;
    prev_ok = 1'b1;
    lane_rd = '0;
    lane_ok = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lane_rd = rd_i[i*L +: L];
      lane_ok = pl_valid_i[i] && !blocked_q && !rst_i
                && prev_ok && !blk_gnt;
      if ((reg_req_i[i*NR +: NR] & eff) != '0) lane_ok = 1'b0;
      if (lane_rd != '0 && eff[lane_rd]) lane_ok = 1'b0;
      if (mem_op_i[i] && (mem_busy_q || mem_gnt)) lane_ok = 1'b0;
      if (blocking_i[i] && (i != 0 || locks_q != '0 || mem_busy_q))
        lane_ok = 1'b0;
      gnt[i]  = lane_ok;
      prev_ok = lane_ok;
      if (lane_ok) begin
        if (lane_rd != '0) begin
          eff[lane_rd]   = 1'b1;
          set_v[lane_rd] = 1'b1;
        end
        mem_gnt = mem_gnt | mem_op_i[i];
        blk_gnt = blk_gnt | blocking_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locks_q    <= '0;
      mem_busy_q <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      mem_busy_q <= (mem_busy_q & ~mem_done_i) | mem_gnt;
      if (blk_gnt) begin
        // A blocking instruction fences every register until it retires.
        locks_q   <= {{(NR-1){1'b1}}, 1'b0};
        blocked_q <= 1'b1;
      end else if (blocked_q && blk_done_i) begin
        locks_q   <= '0;
        blocked_q <= 1'b0;
      end else begin
        // Set after clear: re-locking a released register wins.
        locks_q <= (locks_q & ~wb_clr) | set_v;
      end
    end
  end

  assign gnt_o      = gnt;
  assign locks_o    = locks_q;
  assign mem_busy_o = mem_busy_q;
  assign blocked_o  = blocked_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (NR=32, NI=2, NW=2).
// Drives vectors just after posedge, checks comb and registered outputs.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pl_valid;
  logic [1:0]  blocking;
  logic [9:0]  rd;
  logic [63:0] reg_req;
  logic [1:0]  mem_op;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        mem_done;
  logic        blk_done;
  logic [1:0]  gnt;
  logic [31:0] locks;
  logic        mem_busy;
  logic        blocked;

  int n_chk = 0;
  int n_fail = 0;

  reg_scoreboard #(.NR(32), .NI(2), .NW(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pl_valid_i (pl_valid),
    .blocking_i (blocking),
    .rd_i       (rd),
    .reg_req_i  (reg_req),
    .mem_op_i   (mem_op),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .mem_done_i (mem_done),
    .blk_done_i (blk_done),
    .gnt_o      (gnt),
    .locks_o    (locks),
    .mem_busy_o (mem_busy),
    .blocked_o  (blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pl_valid = '0; blocking = '0; rd = '0; reg_req = '0;
    mem_op = '0; wb_valid = '0; wb_rd = '0;
    mem_done = 1'b0; blk_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    pl_valid = 2'($urandom); blocking = 2'($urandom);
    rd = 10'($urandom); reg_req = {$urandom, $urandom};
    mem_op = 2'($urandom); wb_valid = 2'($urandom);
    wb_rd = 10'($urandom);
    tick(); tick();
    chk("rst_gnt_rand", 32'(gnt), 32'h0);
    chk("rst_locks", locks, 32'h0);
    chk("rst_mem_busy", 32'(mem_busy), 32'h0);
    chk("rst_blocked", 32'(blocked), 32'h0);
    idle();
    pl_valid = 2'b11; rd = {5'd2, 5'd1};
    #1 chk("rst_gnt_ready", 32'(gnt), 32'h0);
    tick();
    chk("rst_no_update", locks, 32'h0);
    rst = 1'b0;
    idle();

    // intra-group RAW
    pl_valid = 2'b11; rd[4:0] = 5'd5; reg_req[32+5] = 1'b1;
    #1 chk("raw_gnt", 32'(gnt), 32'h1);
    tick();
    chk("raw_locks", locks, 32'h0000_0020);
    idle();
    pl_valid = 2'b01; rd[4:0] = 5'd7;
    tick();
    chk("lock7", locks, 32'h0000_00A0);

    // writeback bypass releases r7, r5 still blocks lane1
    idle();
    wb_valid = 2'b01; wb_rd[4:0] = 5'd7;
    pl_valid = 2'b11; reg_req[7] = 1'b1; reg_req[32+5] = 1'b1;
    #1 chk("wb_bypass_gnt", 32'(gnt), 32'h1);
    tick();
    chk("wb_bypass_locks", locks, 32'h0000_0020);

    // set over clear on r5
    idle();
    wb_valid = 2'b01; wb_rd[4:0] = 5'd5;
    pl_valid = 2'b01; rd[4:0] = 5'd5;
    #1 chk("soc_gnt", 32'(gnt), 32'h1);
    tick();
    chk("soc_locks", locks, 32'h0000_0020);

    // WAW stall plus strict in-order
    idle();
    pl_valid = 2'b11; rd[4:0] = 5'd5;
    #1 chk("waw_gnt", 32'(gnt), 32'h0);
    idle();
    wb_valid = 2'b11; wb_rd = {5'd5, 5'd5};
    tick();
    chk("dup_wb_clear", locks, 32'h0);

    // memory serialisation
    idle();
    pl_valid = 2'b11; mem_op = 2'b11;
    #1 chk("mem_pair_gnt", 32'(gnt), 32'h1);
    tick();
    chk("mem_busy_set", 32'(mem_busy), 32'h1);
    idle();
    pl_valid = 2'b01; mem_op = 2'b01; mem_done = 1'b1;
    #1 chk("mem_busy_gnt", 32'(gnt), 32'h0);
    tick();
    chk("mem_done_clr", 32'(mem_busy), 32'h0);

    // rd=0 is never locked
    idle();
    pl_valid = 2'b11;
    #1 chk("r0_gnt", 32'(gnt), 32'h3);
    tick();
    chk("r0_locks", locks, 32'h0);

    // blocking only from lane 0 with an idle scoreboard
    idle();
    pl_valid = 2'b11; rd[4:0] = 5'd2; blocking[1] = 1'b1;
    #1 chk("blk_lane1_gnt", 32'(gnt), 32'h1);
    tick();
    chk("blk_lane1_locks", locks, 32'h0000_0004);
    idle();
    pl_valid = 2'b01; blocking[0] = 1'b1;
    wb_valid = 2'b01; wb_rd[4:0] = 5'd2;
    #1 chk("blk_busy_gnt", 32'(gnt), 32'h0);
    tick();
    chk("blk_busy_locks", locks, 32'h0);

    // blocking grant, hold, release
    idle();
    pl_valid = 2'b11; blocking[0] = 1'b1;
    #1 chk("blk_gnt", 32'(gnt), 32'h1);
    tick();
    chk("blk_locks", locks, 32'hFFFF_FFFE);
    chk("blk_blocked", 32'(blocked), 32'h1);
    idle();
    pl_valid = 2'b11;
    #1 chk("blk_hold_gnt", 32'(gnt), 32'h0);
    blk_done = 1'b1;
    tick();
    chk("blk_done_locks", locks, 32'h0);
    chk("blk_done_blocked", 32'(blocked), 32'h0);
    idle();
    pl_valid = 2'b11;
    #1 chk("post_blk_gnt", 32'(gnt), 32'h3);

    // blk_done while not blocked is ignored
    idle();
    pl_valid = 2'b01; rd[4:0] = 5'd9;
    tick();
    idle();
    blk_done = 1'b1;
    tick();
    chk("blk_done_ignored", locks, 32'h0000_0200);

    // reset overrides a same-cycle grant
    idle();
    rst = 1'b1; pl_valid = 2'b01; rd[4:0] = 5'd12; mem_op = 2'b01;
    #1 chk("rst_mid_gnt", 32'(gnt), 32'h0);
    tick();
    chk("rst_mid_locks", locks, 32'h0);
    chk("rst_mid_mem", 32'(mem_busy), 32'h0);
    rst = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
